tube_event_reader: RTL

Per-event readout controller for the tube counter array. Opens the counting gate on a scintillator trigger and holds it for a fixed window. It then reads every tube's 8-bit cycle count and writes one framed byte record into the event FIFO, stalling while the FIFO is full. Finally it clears the tube counters for the next event. It sits between the tube counter bank and the host-facing FIFO.

---
 rtl/tube_event_reader_if.sv | 17 +
 rtl/tube_event_reader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tube_event_reader_if.sv
// ============================================================================
// Module      : tube_event_reader_if
// Description : Byte-wide write port from the event reader into the event FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface tube_event_reader_if;
    logic [7:0] fifo_din;
    logic       fifo_wr_en;
    logic       fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

`default_nettype wire

// File: rtl/tube_event_reader.sv
// ============================================================================
// Module      : tube_event_reader
// Description : Gates the tube counters on a trigger, then frames all counts
//               into one FIFO record and clears the counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tube_event_reader #(
    parameter int         NUM_TUBES     = 16,
    parameter int         GATE_CYCLES   = 255,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
    input  wire logic                   clk,
    input  wire logic                   clr,
    input  wire logic                   trigger,
    input  wire logic [NUM_TUBES*8-1:0] tube_data,
    output logic                        gate_enable,
    output logic                        tube_clr,
    output logic                        busy,
    output logic [15:0]                 event_seq,
    output logic [7:0]                  dropped,
    tube_event_reader_if.master         fifo
);

    localparam int          IW            = (NUM_TUBES > 1) ? $clog2(NUM_TUBES) : 1;
    localparam logic [15:0] C_GATE_LAST   = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] C_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] C_LAST_TUBE = IW'(NUM_TUBES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GATE   = 3'd1,
        S_SETTLE = 3'd2,
        S_HDR    = 3'd3,
        S_SEQ_HI = 3'd4,
        S_SEQ_LO = 3'd5,
        S_DATA   = 3'd6,
        S_CLEAR  = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_trig_d;
    logic [15:0]     r_cnt;
    logic [IW-1:0]   r_idx;
    logic [15:0]     r_event_seq;
    logic [7:0]      r_dropped;
    logic            w_rise;
    logic [7:0]      w_tube_byte;

    assign w_rise      = trigger & ~r_trig_d;
    assign gate_enable = (r_state == S_GATE);
    assign busy        = (r_state != S_IDLE);
    assign tube_clr    = clr | (r_state == S_CLEAR);
    assign event_seq   = r_event_seq;
    assign dropped     = r_dropped;

    always_comb begin
        w_tube_byte = 8'h00;
        for (int i = 0; i < NUM_TUBES; i++) begin
            if (r_idx == IW'(i)) w_tube_byte = tube_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Write states hold (no byte consumed) whenever the FIFO reports full.
    always_comb begin
        w_next          = r_state;
        fifo.fifo_wr_en = 1'b0;
        fifo.fifo_din   = 8'h00;
        case (r_state)
            S_IDLE:   if (w_rise) w_next = S_GATE;
            S_GATE:   if (r_cnt == C_GATE_LAST) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == C_SETTLE_LAST) w_next = S_HDR;
            S_HDR: begin
                fifo.fifo_din = HEADER_BYTE;
                if (!fifo.fifo_full) begin
                    fifo.fifo_wr_en = 1'b1;
                    w_next          = S_SEQ_HI;
                end
            end
            S_SEQ_HI: begin
                fifo.fifo_din = r_event_seq[15:8];
                if (!fifo.fifo_full) begin
                    fifo.fifo_wr_en = 1'b1;
                    w_next          = S_SEQ_LO;
                end
            end
            S_SEQ_LO: begin
                fifo.fifo_din = r_event_seq[7:0];
                if (!fifo.fifo_full) begin
                    fifo.fifo_wr_en = 1'b1;
                    w_next          = S_DATA;
                end
            end
            S_DATA: begin
                fifo.fifo_din = w_tube_byte;
                if (!fifo.fifo_full) begin
                    fifo.fifo_wr_en = 1'b1;
                    if (r_idx == C_LAST_TUBE) w_next = S_CLEAR;
                end
            end
            S_CLEAR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_trig_d    <= 1'b0;
            r_cnt       <= 16'h0000;
            r_idx       <= '0;
            r_event_seq <= 16'h0000;
            r_dropped   <= 8'h00;
        end else begin
            r_trig_d <= trigger;

            if (r_state == S_IDLE || (r_state == S_GATE && w_next == S_SETTLE))
                r_cnt <= 16'h0000;
            else if (r_state == S_GATE || r_state == S_SETTLE)
                r_cnt <= r_cnt + 16'h0001;

            if (r_state != S_DATA)
                r_idx <= '0;
            else if (fifo.fifo_wr_en)
                r_idx <= r_idx + 1'b1;

            if (r_state == S_CLEAR)
                r_event_seq <= r_event_seq + 16'h0001;

            // Any edge outside IDLE, including the CLEAR cycle, is a lost event.
            if (w_rise && r_state != S_IDLE && r_dropped != 8'hFF)
                r_dropped <= r_dropped + 8'h01;
        end
    end

endmodule

`default_nettype wire
